// File: rtl/spi_cache_ctrl_fsm.sv
// Read-miss controller for a SPI-flash backed cache: device init with timeout,
// tag lookup, line fill from the SPI engine, response pulse and full invalidate.
module spi_cache_ctrl_fsm #(
    parameter int ADDR_W       = 24,
    parameter int LINE_WORDS   = 4,
    parameter int NUM_LINES    = 64,
    parameter int INIT_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_done_i,
    output logic                          init_mode_o,
    output logic                          init_err_o,
    input  logic                          flush_req_i,
    output logic                          flush_busy_o,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_W-1:0]             req_addr_i,
    output logic [ADDR_W-1:0]             lk_addr_o,
    input  logic                          lookup_hit_i,
    output logic                          spi_start_o,
    output logic [ADDR_W-1:0]             spi_addr_o,
    input  logic                          spi_word_valid_i,
    output logic                          fill_we_o,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word_o,
    output logic                          tag_we_o,
    output logic                          inv_we_o,
    output logic [$clog2(NUM_LINES)-1:0]  inv_idx_o,
    output logic                          rsp_valid_o
);

    // state  | meaning
    // INIT   | waiting for SPI device init, timeout counter running
    // IDLE   | accepting requests, or launching a pending flush
    // LOOKUP | tag compare on lk_addr
    // FILL   | line read in progress, one data-array write per SPI word
    // RESP   | one-cycle response pulse
    // FLUSH  | invalidating every line, one per cycle

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int LINE_W = $clog2(NUM_LINES);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int CNT_W  = ($clog2(INIT_TIMEOUT) > 16) ? $clog2(INIT_TIMEOUT) : 16;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(LINE_WORDS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_FILL   = 3'd3,
        S_RESP   = 3'd4,
        S_FLUSH  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    init_cnt_q, init_cnt_d;
    logic                init_err_q, init_err_d;
    logic                flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0]   lk_addr_q, lk_addr_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [LINE_W-1:0]   inv_cnt_q, inv_cnt_d;
    logic                fill_started_q, fill_started_d;

    logic flush_pend;
    logic timeout_hit;
    logic accept;
    logic word_in;
    logic last_word;

    // A flush request arriving in IDLE is treated like one already pending.
    assign flush_pend  = flush_pend_q | flush_req_i;
    assign timeout_hit = (state_q == S_INIT) && !init_done_i && (init_cnt_q == CNT_LAST);
    assign accept      = (state_q == S_IDLE) && !flush_pend && req_valid_i;
    assign word_in     = (state_q == S_FILL) && spi_word_valid_i;
    assign last_word   = word_in && (word_cnt_q == WORD_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   if (init_done_i) state_d = S_IDLE;
            S_IDLE: begin
                if (flush_pend)       state_d = S_FLUSH;
                else if (req_valid_i) state_d = S_LOOKUP;
            end
            S_LOOKUP: state_d = lookup_hit_i ? S_RESP : S_FILL;
            S_FILL:   if (last_word) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            S_FLUSH:  if (inv_cnt_q == LINE_LAST) state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        init_cnt_d     = '0;
        init_err_d     = init_err_q | timeout_hit;
        flush_pend_d   = flush_pend;
        lk_addr_d      = accept ? req_addr_i : lk_addr_q;
        word_cnt_d     = '0;
        inv_cnt_d      = '0;
        fill_started_d = (state_q == S_FILL);
        if (state_q == S_INIT)
            init_cnt_d = (init_cnt_q == CNT_LAST) ? init_cnt_q : init_cnt_q + CNT_W'(1);
        if (state_q == S_IDLE && flush_pend)
            flush_pend_d = 1'b0;
        if (state_q == S_FILL)
            word_cnt_d = last_word ? '0 : (word_in ? word_cnt_q + WORD_W'(1) : word_cnt_q);
        if (state_q == S_FLUSH)
            inv_cnt_d = inv_cnt_q + LINE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q     <= '0;
            init_err_q     <= 1'b0;
            flush_pend_q   <= 1'b0;
            lk_addr_q      <= '0;
            word_cnt_q     <= '0;
            inv_cnt_q      <= '0;
            fill_started_q <= 1'b0;
        end else begin
            init_cnt_q     <= init_cnt_d;
            init_err_q     <= init_err_d;
            flush_pend_q   <= flush_pend_d;
            lk_addr_q      <= lk_addr_d;
            word_cnt_q     <= word_cnt_d;
            inv_cnt_q      <= inv_cnt_d;
            fill_started_q <= fill_started_d;
        end
    end

    // Strobes are gated by rst so a reset landing mid-FILL/FLUSH writes nothing.
    always_comb begin
        init_mode_o  = 1'b0;
        init_err_o   = 1'b0;
        flush_busy_o = 1'b0;
        req_ready_o  = 1'b0;
        spi_start_o  = 1'b0;
        fill_we_o    = 1'b0;
        tag_we_o     = 1'b0;
        inv_we_o     = 1'b0;
        rsp_valid_o  = 1'b0;
        if (rst) begin
            init_mode_o = 1'b1;
        end else begin
            init_err_o = init_err_q | timeout_hit;
            case (state_q)
                S_INIT: init_mode_o = 1'b1;
                S_IDLE: req_ready_o = !flush_pend;
                S_FILL: begin
                    spi_start_o = !fill_started_q;
                    fill_we_o   = spi_word_valid_i;
                    tag_we_o    = last_word;
                end
                S_RESP: rsp_valid_o = 1'b1;
                S_FLUSH: begin
                    flush_busy_o = 1'b1;
                    inv_we_o     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign lk_addr_o   = lk_addr_q;
    assign spi_addr_o  = {lk_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign fill_word_o = word_cnt_q;
    assign inv_idx_o   = inv_cnt_q;

endmodule

// File: tb/tb_spi_cache_ctrl_fsm.sv
// Directed bench for spi_cache_ctrl_fsm: a per-cycle vector table for init, hit
// and miss paths, then hand-written sequences for timeout, flush and reset corners.
module tb_spi_cache_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0, flush_req = 1'b0, req_valid = 1'b0;
    logic [23:0] req_addr = '0;
    logic        lookup_hit = 1'b0, spi_word_valid = 1'b0;
    logic        init_mode, init_err, flush_busy, req_ready, spi_start;
    logic        fill_we, tag_we, inv_we, rsp_valid;
    logic [23:0] lk_addr, spi_addr;
    logic [1:0]  fill_word;
    logic [5:0]  inv_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_cache_ctrl_fsm #(
        .ADDR_W(24), .LINE_WORDS(4), .NUM_LINES(64), .INIT_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .init_done_i(init_done), .init_mode_o(init_mode), .init_err_o(init_err),
        .flush_req_i(flush_req), .flush_busy_o(flush_busy),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .lk_addr_o(lk_addr), .lookup_hit_i(lookup_hit),
        .spi_start_o(spi_start), .spi_addr_o(spi_addr),
        .spi_word_valid_i(spi_word_valid),
        .fill_we_o(fill_we), .fill_word_o(fill_word), .tag_we_o(tag_we),
        .inv_we_o(inv_we), .inv_idx_o(inv_idx), .rsp_valid_o(rsp_valid)
    );

    // {mode, err, busy, ready, start, fill_we, fill_word[1:0], tag_we, rsp, inv_we}
    localparam logic [10:0] E_0 = 11'h000, E_MODE = 11'h400, E_RDY = 11'h080,
                            E_START = 11'h040, E_FWE = 11'h020, E_TAG = 11'h004,
                            E_RSP = 11'h002;
    localparam logic [10:0] W0 = 11'h000, W1 = 11'h008, W2 = 11'h010, W3 = 11'h018;

    typedef struct {
        string       name;
        logic        r, d, f, v;
        logic [23:0] a;
        logic        h, w;
        logic [10:0] e;
        logic [23:0] lk, spi;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic r, d, f, v,
                                input logic [23:0] a, input logic h, w,
                                input logic [10:0] e, input logic [23:0] lk, spi);
        vec_t t;
        t.name = nm; t.r = r; t.d = d; t.f = f; t.v = v; t.a = a;
        t.h = h; t.w = w; t.e = e; t.lk = lk; t.spi = spi;
        return t;
    endfunction

    task automatic drive(input logic r, d, f, v, input logic [23:0] a, input logic h, w);
        @(posedge clk);
        #1;
        rst = r; init_done = d; flush_req = f; req_valid = v;
        req_addr = a; lookup_hit = h; spi_word_valid = w;
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [58:0] act_v, exp_v;

        tbl.push_back(mk("rst0",    1,0,0,0, 24'h0,   0,0, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("rst1",    1,0,0,0, 24'h0,   0,0, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("init_c0", 0,0,0,0, 24'h0,   0,0, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("init_c1", 0,0,0,1, 24'h55,  0,1, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("init_c2", 0,0,0,0, 24'h0,   0,0, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("init_c3", 0,0,0,0, 24'h0,   0,0, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("init_c4", 0,0,0,0, 24'h0,   0,0, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("init_c5", 0,1,0,0, 24'h0,   0,0, E_MODE, 24'h0, 24'h0));
        tbl.push_back(mk("idle_c6", 0,0,0,0, 24'h0,   0,0, E_RDY,  24'h0, 24'h0));
        tbl.push_back(mk("hit_hs",  0,0,0,1, 24'h13C, 0,0, E_RDY,  24'h0, 24'h0));
        tbl.push_back(mk("hit_lk",  0,0,0,0, 24'h0,   1,0, E_0,    24'h13C, 24'h130));
        tbl.push_back(mk("hit_rsp", 0,0,0,0, 24'h0,   0,0, E_RSP,  24'h13C, 24'h130));
        tbl.push_back(mk("miss_hs", 0,0,0,1, 24'h13C, 0,0, E_RDY,  24'h13C, 24'h130));
        tbl.push_back(mk("miss_lk", 0,0,0,0, 24'h0,   0,0, E_0,    24'h13C, 24'h130));
        tbl.push_back(mk("miss_st", 0,0,0,0, 24'h0,   0,0, E_START, 24'h13C, 24'h130));
        tbl.push_back(mk("fill_w0", 0,0,0,0, 24'h0,   0,1, E_FWE|W0, 24'h13C, 24'h130));
        tbl.push_back(mk("fill_g0", 0,0,0,0, 24'h0,   0,0, E_0,    24'h13C, 24'h130));
        tbl.push_back(mk("fill_w1", 0,0,0,0, 24'h0,   0,1, E_FWE|W1, 24'h13C, 24'h130));
        tbl.push_back(mk("fill_w2", 0,0,0,0, 24'h0,   0,1, E_FWE|W2, 24'h13C, 24'h130));
        tbl.push_back(mk("fill_g1", 0,0,0,0, 24'h0,   0,0, E_0,    24'h13C, 24'h130));
        tbl.push_back(mk("fill_w3", 0,0,0,0, 24'h0,   0,1, E_FWE|W3|E_TAG, 24'h13C, 24'h130));
        tbl.push_back(mk("miss_rsp",0,0,0,0, 24'h0,   0,1, E_RSP,  24'h13C, 24'h130));
        tbl.push_back(mk("hs2",     0,0,0,1, 24'hABC, 0,0, E_RDY,  24'h13C, 24'h130));
        tbl.push_back(mk("lk2",     0,0,0,0, 24'h0,   1,1, E_0,    24'hABC, 24'hAB0));
        tbl.push_back(mk("rsp2_rv", 0,0,0,1, 24'h777, 0,0, E_RSP,  24'hABC, 24'hAB0));
        tbl.push_back(mk("idle2",   0,0,0,0, 24'h0,   0,0, E_RDY,  24'hABC, 24'hAB0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].d, tbl[i].f, tbl[i].v, tbl[i].a, tbl[i].h, tbl[i].w);
            act_v = {init_mode, init_err, flush_busy, req_ready, spi_start, fill_we,
                     (fill_we ? fill_word : 2'b00), tag_we, rsp_valid, inv_we,
                     lk_addr, spi_addr};
            exp_v = {tbl[i].e, tbl[i].lk, tbl[i].spi};
            chk(tbl[i].name, 64'(act_v), 64'(exp_v));
        end

        // init timeout: error from cycle 15, sticky through init_done
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            idle_cyc();
            chk("to_err", 64'(init_err), 64'(c >= 15));
            chk("to_mode", 64'(init_mode), 64'd1);
        end
        drive(0, 1, 0, 0, 24'h0, 0, 0);
        chk("to_err_done", 64'(init_err), 64'd1);
        idle_cyc();
        chk("to_idle_mode", 64'(init_mode), 64'd0);
        chk("to_idle_rdy", 64'(req_ready), 64'd1);
        chk("to_err_stay", 64'(init_err), 64'd1);

        // two flush pulses during a fill merge into one flush after RESP
        drive(0, 0, 0, 1, 24'h000208, 0, 0);
        chk("ff_hs", 64'(req_ready), 64'd1);
        drive(0, 0, 0, 0, 24'h0, 0, 0);
        drive(0, 0, 1, 0, 24'h0, 0, 0);
        chk("ff_start", 64'(spi_start), 64'd1);
        chk("ff_spi_addr", 64'(spi_addr), 64'h200);
        for (int w = 0; w < 4; w++) begin
            drive(0, 0, (w == 1), 0, 24'h0, 0, 1);
            chk("ff_we", 64'(fill_we), 64'd1);
            chk("ff_word", 64'(fill_word), 64'(w));
            chk("ff_tag", 64'(tag_we), 64'(w == 3));
            chk("ff_nostart", 64'(spi_start), 64'd0);
            chk("ff_spi_hold", 64'(spi_addr), 64'h200);
        end
        idle_cyc();
        chk("ff_rsp", 64'(rsp_valid), 64'd1);
        chk("ff_rsp_busy", 64'(flush_busy), 64'd0);
        drive(0, 0, 0, 1, 24'hFFFFFF, 0, 0);
        chk("ff_idle_rdy", 64'(req_ready), 64'd0);
        chk("ff_idle_busy", 64'(flush_busy), 64'd0);
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, 0, 1, 24'hFFFFFF, 0, 1);
            chk("fl_busy", 64'(flush_busy), 64'd1);
            chk("fl_inv_we", 64'(inv_we), 64'd1);
            chk("fl_idx", 64'(inv_idx), 64'(i));
            chk("fl_rdy", 64'(req_ready), 64'd0);
            chk("fl_fill_we", 64'(fill_we), 64'd0);
        end
        idle_cyc();
        chk("fl_done_busy", 64'(flush_busy), 64'd0);
        chk("fl_done_inv", 64'(inv_we), 64'd0);
        chk("fl_done_rdy", 64'(req_ready), 64'd1);
        chk("fl_lk_keep", 64'(lk_addr), 64'h208);

        // reset after the second fill word, with a flush pending
        drive(0, 0, 0, 1, 24'h001234, 0, 0);
        chk("rf_hs", 64'(req_ready), 64'd1);
        drive(0, 0, 0, 0, 24'h0, 0, 0);
        drive(0, 0, 0, 0, 24'h0, 0, 0);
        chk("rf_start", 64'(spi_start), 64'd1);
        drive(0, 0, 1, 0, 24'h0, 0, 1);
        chk("rf_w0", 64'(fill_we), 64'd1);
        drive(0, 0, 0, 0, 24'h0, 0, 1);
        chk("rf_w1", 64'(fill_word), 64'd1);
        drive(1, 0, 0, 0, 24'h0, 0, 1);
        chk("rf_rst_we", 64'(fill_we), 64'd0);
        chk("rf_rst_mode", 64'(init_mode), 64'd1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 24'h0, 0, 1);
            chk("rf_we", 64'(fill_we), 64'd0);
            chk("rf_tag", 64'(tag_we), 64'd0);
            chk("rf_mode", 64'(init_mode), 64'd1);
            chk("rf_err", 64'(init_err), 64'd0);
            chk("rf_lk", 64'(lk_addr), 64'h0);
        end
        drive(0, 1, 0, 0, 24'h0, 0, 0);
        idle_cyc();
        chk("rf_pend_clr", 64'(req_ready), 64'd1);

        // flush requested in INIT, another during FLUSH, then flush beats req_valid
        drive(1, 0, 0, 0, 24'h0, 0, 0);
        drive(0, 0, 1, 0, 24'h0, 0, 0);
        chk("if_mode", 64'(init_mode), 64'd1);
        drive(0, 1, 0, 0, 24'h0, 0, 0);
        drive(0, 0, 0, 1, 24'h000040, 0, 0);
        chk("if_idle_rdy", 64'(req_ready), 64'd0);
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, (i == 5), 0, 24'h0, 0, 0);
            chk("if_idx", 64'(inv_idx), 64'(i));
            chk("if_busy", 64'(flush_busy), 64'd1);
        end
        idle_cyc();
        chk("if2_rdy", 64'(req_ready), 64'd0);
        chk("if2_busy", 64'(flush_busy), 64'd0);
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, 0, 0, 24'h0, 0, 0);
            chk("if2_idx", 64'(inv_idx), 64'(i));
        end
        drive(0, 0, 1, 1, 24'h000080, 0, 0);
        chk("pri_rdy", 64'(req_ready), 64'd0);
        idle_cyc();
        chk("pri_busy", 64'(flush_busy), 64'd1);
        chk("pri_lk", 64'(lk_addr), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
